// File: rtl/instr_mem_pkg.sv
// instr_mem_pkg: shared instruction-set constants for the fetch path.
//   INSTRUCTION_WIDTH       - instruction word width
//   OP_* / R*               - opcode and register field codes
//   asm()                   - packs {opcode, register} into one instruction word
//   INSTR_MEM_ADDR_WIDTH    - default instruction memory address width
//   INSTR_MEM_DEPTH         - default number of implemented instruction words
package instr_mem_pkg;

    localparam int unsigned INSTRUCTION_WIDTH = 8;
    localparam int unsigned OP_WIDTH          = 5;
    localparam int unsigned REG_WIDTH         = 3;

    localparam logic [OP_WIDTH-1:0] OP_NOP = 5'h10;
    localparam logic [OP_WIDTH-1:0] OP_ADD = 5'h01;

    localparam logic [REG_WIDTH-1:0] R0 = 3'd0;
    localparam logic [REG_WIDTH-1:0] R3 = 3'd3;

    localparam int unsigned INSTR_MEM_ADDR_WIDTH = 5;
    localparam int unsigned INSTR_MEM_DEPTH      = 32;

    function automatic logic [INSTRUCTION_WIDTH-1:0] asm(input logic [OP_WIDTH-1:0]  op,
                                                         input logic [REG_WIDTH-1:0] rd);
        return {op, rd};
    endfunction

endpackage

// File: rtl/instr_mem_if.sv
// instr_mem_if: fetch and program-load bus of the instruction memory.
//   master (fetch stage / loader): drives fetch_req, fetch_addr, fetch_stall, wr_en, wr_addr,
//                                  wr_data; receives ready, fetch_data, fetch_valid, fetch_oob
//   slave  (instr_mem):            the reverse
// With INSTR_MEM_PARITY_EN defined the bus also carries fetch_perr (slave -> master).
interface instr_mem_if #(
    parameter int unsigned INSTR_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH  = 5
);
    logic                   ready;
    logic                   fetch_req;
    logic [ADDR_WIDTH-1:0]  fetch_addr;
    logic                   fetch_stall;
    logic [INSTR_WIDTH-1:0] fetch_data;
    logic                   fetch_valid;
    logic                   fetch_oob;
    logic                   wr_en;
    logic [ADDR_WIDTH-1:0]  wr_addr;
    logic [INSTR_WIDTH-1:0] wr_data;
`ifdef INSTR_MEM_PARITY_EN
    logic                   fetch_perr;

    modport master (
        input  ready, fetch_data, fetch_valid, fetch_oob, fetch_perr,
        output fetch_req, fetch_addr, fetch_stall, wr_en, wr_addr, wr_data
    );
    modport slave (
        output ready, fetch_data, fetch_valid, fetch_oob, fetch_perr,
        input  fetch_req, fetch_addr, fetch_stall, wr_en, wr_addr, wr_data
    );
`else
    modport master (
        input  ready, fetch_data, fetch_valid, fetch_oob,
        output fetch_req, fetch_addr, fetch_stall, wr_en, wr_addr, wr_data
    );
    modport slave (
        output ready, fetch_data, fetch_valid, fetch_oob,
        input  fetch_req, fetch_addr, fetch_stall, wr_en, wr_addr, wr_data
    );
`endif
endinterface

// File: rtl/instr_mem_array.sv
// instr_mem_array: synchronous single-write, single-read RAM, read-before-write.
//   clk   - clock
//   we    - write enable; waddr/wdata write on the rising edge
//   re    - read enable; rdata <= mem[raddr] on the rising edge, held while re is low
//   rdata - registered read data (old word on a same-address read/write)
// Callers must keep waddr/raddr below DEPTH whenever we/re are high.
module instr_mem_array #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned DEPTH      = 32,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [WIDTH-1:0]      rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end
endmodule

// File: rtl/instr_mem.sv
// instr_mem: parametrised instruction memory with a registered, stallable fetch port and a
// runtime program-load write port. After reset a clear sequencer fills every word with NOP_WORD
// (DEPTH cycles); ready rises once that completes.
//   clk, rst_n - clock, asynchronous active-low reset
//   bus        - instr_mem_if.slave: ready, fetch_req/addr/stall -> fetch_data/valid/oob,
//                wr_en/addr/data
// Optional macro INSTR_MEM_PARITY_EN: stores an even-parity bit per word and reports a mismatch
// on fetch_perr alongside fetch_data.
module instr_mem
    import instr_mem_pkg::*;
#(
    parameter int unsigned            INSTR_WIDTH = INSTRUCTION_WIDTH,
    parameter int unsigned            ADDR_WIDTH  = INSTR_MEM_ADDR_WIDTH,
    parameter int unsigned            DEPTH       = INSTR_MEM_DEPTH,
    parameter logic [INSTR_WIDTH-1:0] NOP_WORD    = asm(OP_NOP, R0)
) (
    input logic       clk,
    input logic       rst_n,
    instr_mem_if.slave bus
);
`ifdef INSTR_MEM_PARITY_EN
    localparam int unsigned WORD_WIDTH = INSTR_WIDTH + 1;
`else
    localparam int unsigned WORD_WIDTH = INSTR_WIDTH;
`endif
    localparam int unsigned            LAST      = DEPTH - 1;
    localparam logic [ADDR_WIDTH-1:0]  LAST_ADDR = LAST[ADDR_WIDTH-1:0];
    // One extra bit so DEPTH == 2**ADDR_WIDTH is representable.
    localparam logic [ADDR_WIDTH:0]    DEPTH_X   = DEPTH[ADDR_WIDTH:0];

    typedef enum logic {StClear = 1'b0, StRun = 1'b1} state_e;

    function automatic logic [WORD_WIDTH-1:0] encode(input logic [INSTR_WIDTH-1:0] d);
`ifdef INSTR_MEM_PARITY_EN
        return {^d, d};
`else
        return d;
`endif
    endfunction

    state_e                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  clr_cnt_q, clr_cnt_d;
    logic                   valid_q, valid_d;
    logic                   oob_q, oob_d;
    // Forces fetch_data to NOP_WORD after reset and after an out-of-range fetch, since the
    // RAM read register has no reset and is not loaded for out-of-range addresses.
    logic                   nop_sel_q, nop_sel_d;

    logic                   mem_we;
    logic [ADDR_WIDTH-1:0]  mem_waddr;
    logic [WORD_WIDTH-1:0]  mem_wdata;
    logic                   mem_re;
    logic [WORD_WIDTH-1:0]  rdata;

    logic ready;
    logic accept;
    logic fetch_in_range;
    logic wr_in_range;

    assign ready          = (state_q == StRun);
    assign fetch_in_range = ({1'b0, bus.fetch_addr} < DEPTH_X);
    assign wr_in_range    = ({1'b0, bus.wr_addr} < DEPTH_X);
    assign accept         = ready & bus.fetch_req & ~bus.fetch_stall;
    assign mem_re         = accept & fetch_in_range;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StClear;
            clr_cnt_q <= '0;
            valid_q   <= 1'b0;
            oob_q     <= 1'b0;
            nop_sel_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            valid_q   <= valid_d;
            oob_q     <= oob_d;
            nop_sel_q <= nop_sel_d;
        end
    end

    // Clear sequencer and write-port steering.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        mem_we    = 1'b0;
        mem_waddr = bus.wr_addr;
        mem_wdata = encode(bus.wr_data);
        unique case (state_q)
            StClear: begin
                mem_we    = 1'b1;
                mem_waddr = clr_cnt_q;
                mem_wdata = encode(NOP_WORD);
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == LAST_ADDR) begin
                    state_d   = StRun;
                    clr_cnt_d = '0;
                end
            end
            StRun: begin
                mem_we = bus.wr_en & wr_in_range;
            end
            default: begin
                state_d = StClear;
            end
        endcase
    end

    // Fetch register: everything holds while stalled.
    always_comb begin
        valid_d   = valid_q;
        oob_d     = oob_q;
        nop_sel_d = nop_sel_q;
        if (!bus.fetch_stall) begin
            valid_d = accept;
            if (accept) begin
                oob_d     = ~fetch_in_range;
                nop_sel_d = ~fetch_in_range;
            end
        end
    end

    instr_mem_array #(
        .WIDTH      (WORD_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .re    (mem_re),
        .raddr (bus.fetch_addr),
        .rdata (rdata)
    );

    assign bus.ready       = ready;
    assign bus.fetch_valid = valid_q;
    assign bus.fetch_oob   = oob_q;
    assign bus.fetch_data  = nop_sel_q ? NOP_WORD : rdata[INSTR_WIDTH-1:0];
`ifdef INSTR_MEM_PARITY_EN
    // Stored word includes its parity bit, so a clean word XORs to zero.
    assign bus.fetch_perr  = ~nop_sel_q & (^rdata);
`endif
endmodule

// File: doc/instr_mem.md
Name: instr_mem

Overview:
Parametrised instruction memory that succeeds the fixed 32-entry combinational program ROM. It provides a registered fetch port with a stall handshake and a runtime program-load write port. A hardware clear sequencer fills every word with NOP after reset. It sits between the program counter/fetch stage and the instruction decoder, and the loader/testbench writes programs through the write port.

Parameters:
INSTR_WIDTH, `INSTRUCTION_WIDTH (8): instruction word width in bits.
ADDR_WIDTH, 5: fetch and write address width.
DEPTH, 32: number of implemented words; legal range 2..2**ADDR_WIDTH.
NOP_WORD, `ASM(`NOP, `R0): fill value used by clear and by out-of-range fetch.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst_n  in  1  asynchronous active-low reset.
ready  out  1  high when the clear sequence is complete; fetch and write are accepted only when this is high.
fetch_req  in  1  fetch request, sampled on clk.
fetch_addr  in  ADDR_WIDTH  fetch address.
fetch_stall  in  1  consumer stall; holds fetch_data and fetch_valid.
fetch_data  out  INSTR_WIDTH  registered instruction.
fetch_valid  out  1  fetch_data holds the result of an accepted fetch.
fetch_oob  out  1  the accepted fetch address was >= DEPTH.
wr_en  in  1  program-load write strobe.
wr_addr  in  ADDR_WIDTH  write address.
wr_data  in  INSTR_WIDTH  write data.

Behaviour:
- Reset values (rst_n low, asynchronous):
  - ready=0, fetch_valid=0, fetch_oob=0, fetch_data=NOP_WORD.
  - FSM=CLEAR, clear counter=0.
  - The memory array is not reset.
- FSM states: CLEAR, RUN.
  - CLEAR: writes NOP_WORD to address clr_cnt each cycle and increments clr_cnt.
  - CLEAR lasts exactly DEPTH cycles after reset deasserts. When clr_cnt==DEPTH-1, the next state is RUN.
  - ready rises on the first RUN cycle.
  - During CLEAR, fetch_req and wr_en are ignored and fetch_valid stays 0.
  - RUN persists until reset.
- Fetch acceptance: a fetch is accepted when ready & fetch_req & !fetch_stall. One-cycle latency: on the next edge, fetch_data=mem[fetch_addr] and fetch_valid=1.
- No request, not stalled: with !fetch_req & !fetch_stall, fetch_valid drops to 0 on the next edge and fetch_data holds its last value.
- Stall: with fetch_stall=1, fetch_data, fetch_valid and fetch_oob hold regardless of fetch_req. A request made while stalled is dropped, not queued.
- Out of range: if fetch_addr >= DEPTH, fetch_data=NOP_WORD, fetch_oob=1 and fetch_valid=1. Otherwise fetch_oob=0.
- Write: when ready & wr_en & wr_addr<DEPTH, mem[wr_addr] <= wr_data on the edge. An out-of-range write is silently discarded. Writes are not affected by fetch_stall.
- Same address fetched and written in one cycle: read-before-write. fetch_data returns the old word, and the new word is visible to the next fetch.
- Reset mid-operation:
  - Re-enters CLEAR and drops ready and fetch_valid immediately (asynchronously).
  - A write in flight at reset is not guaranteed.
  - CLEAR restarts from address 0.

Optional Feature:
Macro INSTR_MEM_PARITY_EN.
- Defined:
  - Each word stores INSTR_WIDTH+1 bits, the extra bit being even parity of the data.
  - Clear and write generate the parity bit.
  - Adds output fetch_perr (1 bit, reset 0), registered with fetch_data. It is 1 when the stored parity mismatches on an accepted in-range fetch, and obeys stall hold.
  - fetch_data is passed through unmodified.
- Undefined: no parity storage and no fetch_perr port.

Decomposition:
- OpCodes.v shared header holds `INSTRUCTION_WIDTH, opcode/register codes and the `ASM macro used for NOP_WORD.
- Add `INSTR_MEM_ADDR_WIDTH and `INSTR_MEM_DEPTH defaults there.
- FSM state encodings (CLEAR=1'b0, RUN=1'b1) are localparams inside the module.
- One sub-module, instr_mem_array: a plain synchronous single-write, single-read RAM, parametrised by width and depth, with read-before-write. It is instantiated with width INSTR_WIDTH or INSTR_WIDTH+1.
- Clear sequencer, fetch register and out-of-range logic stay in instr_mem.

Test Plan:
- Reset release, DEPTH=32: ready=0 for exactly 32 cycles, then 1. A fetch of each of addresses 0..31 returns NOP_WORD with fetch_valid=1 one cycle later.
- Load and fetch: write mem[3]=`ASM(`ADD,`R3). Fetch addr 3 on the next cycle, then fetch_data=`ASM(`ADD,`R3) and fetch_valid=1. Back-to-back fetches 0,1,2 return three words on consecutive cycles.
- Stall: fetch addr 3, then assert fetch_stall for 4 cycles while fetch_req=1 with addr 5. fetch_data holds mem[3] and fetch_valid=1 throughout. After release, the next accepted fetch returns mem[5].
- Collision: with mem[7]=A, write B to 7 and fetch 7 in the same cycle. Result is A. The following fetch of 7 returns B.
- Out of range, DEPTH=20, ADDR_WIDTH=5:
  - fetch 25 gives NOP_WORD, fetch_oob=1, fetch_valid=1.
  - write to 25 followed by fetch 25 still gives NOP_WORD.
  - fetch 19 gives fetch_oob=0.
- Reset mid-run: assert rst_n=0 asynchronously mid-cycle. ready and fetch_valid drop immediately. After release, ready reasserts after DEPTH cycles and all words read NOP_WORD. With INSTR_MEM_PARITY_EN, a forced parity bit flip on word 2 gives fetch_perr=1.
